pixel_store: RTL

Downsampled framebuffer and pixel-output stage, directly downstream of the VGA timing generator. It consumes the raster position (vgaX, vgaY) and the hsync/vsync/blank_b/sync_b timing signals. It returns 8-bit-per-channel RGB to the video DAC, with the timing signals delayed so they stay aligned with the pixel data. A write port with a valid/ready handshake, plus an optional full-screen clear engine, lets the game/MCU-interface logic update the picture while it is being displayed.

---
 rtl/pixel_store_pkg.sv | 40 ++++
 rtl/fb_ram.sv | 33 +++
 rtl/pixel_store.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_store_pkg.sv
// pixel_store_pkg -- shared types and constants for the pixel_store framebuffer.
//   color_t   : palette index type
//   rgb_t     : packed 24-bit colour (r, g, b)
//   PALETTE   : fixed 8-entry index -> RGB map
//   state_t   : write-side state machine states
//   FB_W_DEF / FB_H_DEF / SCALE_LOG2_DEF / COLOR_W_DEF : default geometry
`timescale 1ns/1ps
package pixel_store_pkg;

    localparam int FB_W_DEF       = 160;
    localparam int FB_H_DEF       = 120;
    localparam int SCALE_LOG2_DEF = 2;
    localparam int COLOR_W_DEF    = 3;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Element 0 is the rightmost entry of the concatenation.
    localparam rgb_t [7:0] PALETTE = {
        24'hFFFFFF,   // 7 white
        24'hFF00FF,   // 6 magenta
        24'h00FFFF,   // 5 cyan
        24'hFFFF00,   // 4 yellow
        24'h0000FF,   // 3 blue
        24'h00FF00,   // 2 green
        24'hFF0000,   // 1 red
        24'h000000    // 0 black
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/fb_ram.sv
// fb_ram -- simple dual-port RAM, one write port and one registered read port,
// written so it maps onto iCE40 EBR. Contents are not reset.
//   i_clk              : clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr            : read address, data appears on o_rdata one cycle later
`timescale 1ns/1ps
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // A read of the address being written returns the old contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_store.sv
// pixel_store -- downsampled framebuffer and pixel output stage behind the VGA
// timing generator.
//   vgaclk, reset (sync, active low)
//   vgaX/vgaY, hsync/vsync/sync_b/blank_b : raster position and timing in
//   wr_valid/wr_ready, wr_x/wr_y/wr_color : pixel write handshake
//   clr_start/clr_color/clr_busy          : full-screen clear (only with
//                                           PIXEL_STORE_CLEAR_EN defined)
//   r/g/b, hsync_o/vsync_o/sync_b_o/blank_b_o : DAC data and aligned timing
// Read path is three registers deep: address, RAM read, palette/blank.
`timescale 1ns/1ps
module pixel_store
    import pixel_store_pkg::*;
#(
    parameter int FB_W       = FB_W_DEF,
    parameter int FB_H       = FB_H_DEF,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int COLOR_W    = COLOR_W_DEF
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic [9:0]         vgaX,
    input  logic [9:0]         vgaY,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               sync_b,
    input  logic               blank_b,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [7:0]         wr_x,
    input  logic [6:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_color,
`ifdef PIXEL_STORE_CLEAR_EN
    input  logic               clr_start,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_busy,
`endif
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               sync_b_o,
    output logic               blank_b_o
);

    localparam int             DEPTH  = FB_W * FB_H;
    localparam int             AW     = $clog2(DEPTH);
    localparam logic [9:0]     LAST_X = 10'(FB_W - 1);
    localparam logic [9:0]     LAST_Y = 10'(FB_H - 1);
    // Timing bundle order is {hsync, vsync, sync_b, blank_b}.
    localparam logic [3:0]     TIM_RST = 4'b1110;

    // Row-major address; the default width of 160 uses 128+32 shifts.
    function automatic logic [AW-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        logic [AW-1:0] xa;
        logic [AW-1:0] ya;
        xa = AW'(x);
        ya = AW'(y);
        if (FB_W == 160) begin
            return (ya << 7) + (ya << 5) + xa;
        end else begin
            return (ya * AW'(FB_W)) + xa;
        end
    endfunction

    // ---------------- write side ----------------
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [COLOR_W-1:0] w_wdata;
    logic [AW-1:0]      w_wr_addr;
    logic               w_wr_in_range;
    logic               r_ready;

    assign w_wr_addr     = fb_addr({2'b00, wr_x}, {3'b000, wr_y});
    assign w_wr_in_range = ({2'b00, wr_x} <= LAST_X) && ({3'b000, wr_y} <= LAST_Y);
    assign wr_ready      = r_ready;

`ifdef PIXEL_STORE_CLEAR_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_clr_addr;
    logic [COLOR_W-1:0] r_clr_color;

    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == ST_IDLE);
            if (r_state == ST_IDLE) begin
                r_clr_addr <= '0;
                if (clr_start) begin
                    r_clr_color <= clr_color;
                end
            end else begin
                r_clr_addr <= r_clr_addr + AW'(1);
            end
        end
    end

    // A write accepted in the same cycle as clr_start lands first; the clear
    // then sweeps over it.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = w_wr_addr;
        w_wdata      = wr_color;
        case (r_state)
            ST_IDLE: begin
                w_we = reset && wr_valid && r_ready && w_wr_in_range;
                if (clr_start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_we    = reset;
                w_waddr = r_clr_addr;
                w_wdata = r_clr_color;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign clr_busy = (r_state == ST_CLEAR);
`else
    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    always_comb begin
        w_we    = reset && wr_valid && r_ready && w_wr_in_range;
        w_waddr = w_wr_addr;
        w_wdata = wr_color;
    end
`endif

    // ---------------- read side ----------------
    logic [9:0]         w_rd_x;
    logic [9:0]         w_rd_y;
    logic [9:0]         w_rd_xc;
    logic [9:0]         w_rd_yc;
    logic [AW-1:0]      r_rd_addr;
    logic [COLOR_W-1:0] w_rd_data;
    logic [3:0]         r_tim_s1;
    logic [3:0]         r_tim_s2;
    logic [3:0]         r_tim_s3;
    rgb_t               r_rgb;

    assign w_rd_x  = vgaX >> SCALE_LOG2;
    assign w_rd_y  = vgaY >> SCALE_LOG2;
    assign w_rd_xc = (w_rd_x > LAST_X) ? LAST_X : w_rd_x;
    assign w_rd_yc = (w_rd_y > LAST_Y) ? LAST_Y : w_rd_y;

    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (COLOR_W)
    ) u_fb_ram (
        .i_clk   (vgaclk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Stage 2 is the RAM's own output register, so the timing bundle takes
    // one extra plain register there to stay aligned.
    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_tim_s1  <= TIM_RST;
            r_tim_s2  <= TIM_RST;
            r_tim_s3  <= TIM_RST;
            r_rgb     <= '0;
        end else begin
            r_rd_addr <= fb_addr(w_rd_xc, w_rd_yc);
            r_tim_s1  <= {hsync, vsync, sync_b, blank_b};
            r_tim_s2  <= r_tim_s1;
            r_tim_s3  <= r_tim_s2;
            r_rgb     <= r_tim_s2[0] ? PALETTE[color_t'(w_rd_data)] : '0;
        end
    end

    assign r         = r_rgb.r;
    assign g         = r_rgb.g;
    assign b         = r_rgb.b;
    assign hsync_o   = r_tim_s3[3];
    assign vsync_o   = r_tim_s3[2];
    assign sync_b_o  = r_tim_s3[1];
    assign blank_b_o = r_tim_s3[0];

endmodule
